xoshiro256_stream: RTL
======================

Name: xoshiro256_stream

Overview:
- Parametrised successor to the single-lane xorshift256+ generator.
- Holds LANES independent xoshiro256 states and runtime-selects the scrambler: plus, plusplus or starstar.
- Seeds lane 0 directly. Seeds lanes 1..LANES-1 by successive 2^128-step jumps from an internal jump engine, so lane streams do not overlap.
- Delivers LANES*64 bits per beat over a valid/ready stream; feeds wide randomness consumers (dither, test-pattern, Monte-Carlo blocks).

Parameters:
- LANES, 2, number of parallel 64-bit generator lanes (1..8).
- DEFAULT_MODE, 0, scrambler in force after reset (0 plus, 1 plusplus, 2 starstar).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- seed_valid  in  1  seed load request.
- seed_ready  out  1  seed load accepted when seed_valid && seed_ready.
- seed  in  256  {s3,s2,s1,s0} for lane 0.
- mode  in  2  scrambler select, captured together with seed.
- out_valid  out  1  out carries a valid word.
- out_ready  in  1  consumer accepts out.
- out  out  LANES*64  lane k occupies bits [64k+63:64k].
- busy  out  1  high while the jump engine fills lanes.

Behaviour:
- Reset (async, rst_n=0):
  - All lane states, jump registers and counters clear to 0; mode_q = DEFAULT_MODE; FSM = IDLE.
  - out_valid=0, seed_ready=1, busy=0, out=0.
- Step function (per lane, 64-bit wrap arithmetic):
  - t=s1<<17; s2^=s0; s3^=s1; s1^=s2; s0^=s3; s2^=t; s3=rotl(s3,45).
- Scramblers (combinational from the current lane state, so out latency is 0 cycles):
  - plus: s0+s3.
  - plusplus: rotl(s0+s3,23)+s0.
  - starstar: rotl(s1*5,7)*9.
  - mode value 3 behaves as plus.
- FSM states IDLE, JUMP, RUN:
  - IDLE: out_valid=0, seed_ready=1.
  - Seed accept, from IDLE or RUN:
    - lane0 <= seed; an all-zero seed is replaced by s0=1, others 0; mode_q <= mode.
    - If LANES=1, next state RUN; otherwise JUMP with lane index k=1, work w=lane0, acc=0, cnt=0.
  - JUMP:
    - seed_ready=0, out_valid=0, busy=1.
    - Each cycle: if bit cnt of the jump constant is 1, acc^=w; then w=step(w); cnt++.
    - Jump constant is the 256-bit concatenation, LSB word first: 0x180EC6D33CFD0ABA, 0xD5A61266F0C9392C, 0xA9582618E03FC9AA, 0x39ABDC4529B1661C.
    - At cnt=255, the final acc (including that cycle's XOR) is written to lane k. Then w=that value, acc=0, cnt=0, k++.
    - After lane LANES-1 is written, next state RUN.
    - Duration is exactly 256*(LANES-1) cycles.
  - RUN:
    - out_valid=1, seed_ready=1.
    - On out_valid && out_ready, all lanes step together at that edge.
    - No handshake means state and out are held stable.
  - A seed accepted in RUN has priority over a simultaneous out handshake: the lanes load the seed and do not step.
  - seed_valid during JUMP is ignored (seed_ready=0) and must be held by the source.
- Mid-operation reset aborts JUMP immediately; the next seed restarts the fill from lane 1.
- mode changes take effect only at seed accept.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, release -> out_valid=0, seed_ready=1, busy=0, out=0.
- LANES=1, mode=0, seed s0=1, others 0 -> out_valid=1 one cycle after accept. Successive accepted outputs 0x1, 0x1, 0x0000200000000000.
- LANES=1, same seed, mode=1 -> first out 0x0000000000800001. With seed s1=1, others 0 and mode=2 -> first out 0x0000000000001680.
- LANES=2, nonzero seed -> busy high exactly 256 cycles, then out_valid=1.
  - Lane 1 must equal the C reference jump() applied to lane 0's seed.
  - Lane 0 output must equal the single-lane sequence for the same seed.
- Backpressure: hold out_ready=0 for 10 cycles in RUN -> out constant. Toggle out_ready every cycle -> sequence advances only on handshake cycles, with no skipped or repeated words.
- Boundaries, each scenario run separately:
  - All-zero seed -> behaves as s0=1 seed.
  - seed_valid asserted mid-JUMP -> seed_ready=0, and the seed is not loaded until RUN.
  - rst_n pulsed at jump cycle 100 -> busy=0, FSM in IDLE, fresh seed completes a full 256-cycle fill.

Source files
------------

// File: rtl/xoshiro256_stream.sv
// Multi-lane xoshiro256 generator streaming LANES*64 bits per beat.
// Lane 0 is seeded directly. Lanes 1..LANES-1 are filled by successive
// 2^128-step jumps, so the lane streams never overlap.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   seed_valid/ready   seed load handshake; seed = {s3,s2,s1,s0} for lane 0
//   mode               scrambler select captured with seed (0 plus, 1 plusplus, 2 starstar)
//   out_valid/ready    output stream handshake; lane k at out[64k+63:64k]
//   busy               high while the jump engine fills lanes
module xoshiro256_stream #(
    parameter int unsigned LANES        = 2,
    parameter int unsigned DEFAULT_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  seed_valid,
    output logic                  seed_ready,
    input  logic [255:0]          seed,
    input  logic [1:0]            mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*64-1:0]   out,
    output logic                  busy
);

    localparam int unsigned KW = (LANES > 1) ? $clog2(LANES) : 1;

    // Jump polynomial, LSB word first (bit cnt selects the term).
    localparam logic [255:0] JUMP_CONST = {
        64'h39ABDC4529B1661C, 64'hA9582618E03FC9AA,
        64'hD5A61266F0C9392C, 64'h180EC6D33CFD0ABA
    };

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_JUMP = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [255:0]  lane_q [LANES];
    logic [255:0]  work_q;
    logic [255:0]  acc_q;
    logic [7:0]    cnt_q;
    logic [KW-1:0] k_q;
    logic [1:0]    mode_q;

    logic          seed_fire;
    logic          out_fire;
    logic          jump_last;
    logic          lane_last;
    logic [255:0]  acc_nxt;
    logic [255:0]  seed_fix;

    // One xoshiro256 state transition; state packed as {s3,s2,s1,s0}.
    function automatic logic [255:0] xo_step(input logic [255:0] s);
        logic [63:0] s0, s1, s2, s3, t;
        s0 = s[63:0];
        s1 = s[127:64];
        s2 = s[191:128];
        s3 = s[255:192];
        t  = s1 << 17;
        s2 = s2 ^ s0;
        s3 = s3 ^ s1;
        s1 = s1 ^ s2;
        s0 = s0 ^ s3;
        s2 = s2 ^ t;
        s3 = {s3[18:0], s3[63:19]};
        return {s3, s2, s1, s0};
    endfunction

    // Output scrambler; mode 3 falls back to plus.
    function automatic logic [63:0] xo_scramble(input logic [255:0] s, input logic [1:0] m);
        logic [63:0] sum, mul;
        sum = s[63:0] + s[255:192];
        mul = s[127:64] * 64'd5;
        case (m)
            2'd1:    xo_scramble = {sum[40:0], sum[63:41]} + s[63:0];
            2'd2:    xo_scramble = {mul[56:0], mul[63:57]} * 64'd9;
            default: xo_scramble = sum;
        endcase
    endfunction

    assign seed_fire = seed_valid && seed_ready;
    assign out_fire  = out_valid && out_ready;
    assign jump_last = (cnt_q == 8'd255);
    assign lane_last = (k_q == KW'(LANES - 1));
    assign acc_nxt   = JUMP_CONST[cnt_q] ? (acc_q ^ work_q) : acc_q;
    // All-zero state is a fixed point of the step; substitute s0=1.
    assign seed_fix  = (seed == '0) ? 256'd1 : seed;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (seed_fire) state_d = (LANES == 1) ? ST_RUN : ST_JUMP;
            end
            ST_JUMP: begin
                if (jump_last && lane_last) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (seed_fire) state_d = (LANES == 1) ? ST_RUN : ST_JUMP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered status outputs decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            seed_ready <= 1'b1;
            busy       <= 1'b0;
        end else begin
            out_valid  <= (state_d == ST_RUN);
            seed_ready <= (state_d != ST_JUMP);
            busy       <= (state_d == ST_JUMP);
        end
    end

    // Lane states and jump engine; seed load wins over an output step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < LANES; i++) lane_q[i] <= '0;
            work_q <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            k_q    <= '0;
            mode_q <= 2'(DEFAULT_MODE);
        end else if (seed_fire) begin
            lane_q[0] <= seed_fix;
            mode_q    <= mode;
            work_q    <= seed_fix;
            acc_q     <= '0;
            cnt_q     <= '0;
            k_q       <= KW'(1);
        end else if (state_q == ST_JUMP) begin
            if (jump_last) begin
                for (int unsigned i = 1; i < LANES; i++) begin
                    if (k_q == KW'(i)) lane_q[i] <= acc_nxt;
                end
                work_q <= acc_nxt;
                acc_q  <= '0;
                cnt_q  <= '0;
                k_q    <= k_q + KW'(1);
            end else begin
                work_q <= xo_step(work_q);
                acc_q  <= acc_nxt;
                cnt_q  <= cnt_q + 8'd1;
            end
        end else if (out_fire) begin
            for (int unsigned i = 0; i < LANES; i++) lane_q[i] <= xo_step(lane_q[i]);
        end
    end

    // Zero-latency scrambled output per lane
    always_comb begin
        out = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            out[64*i +: 64] = xo_scramble(lane_q[i], mode_q);
        end
    end

endmodule
